// File: rtl/alu_serial_exec_if.sv
// Handshake and operand/result bundle between the execute-stage ALU and its controller.
interface alu_serial_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            Operation;
    logic                  is_branch;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  BrTaken;

    modport master (
        output start, Operation, is_branch, SrcA, SrcB,
        input  busy, done, ALUResult, BrTaken
    );

    modport slave (
        input  start, Operation, is_branch, SrcA, SrcB,
        output busy, done, ALUResult, BrTaken
    );
endinterface

// File: rtl/alu_serial_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare, 1-bit-per-cycle serial shifter.
module alu_serial_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input logic               clk,
    input logic               reset,
    alu_serial_exec_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

    state_t                 state, state_next;
    shift_t                 sh_kind;
    logic [DATA_WIDTH-1:0]  work;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   is_shift;
    logic                   last_step;
    logic [DATA_WIDTH-1:0]  imm_result;
    logic                   imm_taken;
    logic                   lt_signed;

    assign shamt     = bus.SrcB[SHAMT_WIDTH-1:0];
    assign lt_signed = $signed(bus.SrcA) < $signed(bus.SrcB);
    assign is_shift  = !bus.is_branch &&
                       (bus.Operation == 4'b0100 || bus.Operation == 4'b0101 ||
                        bus.Operation == 4'b1101);
    assign last_step = (cnt == SHAMT_WIDTH'(1));

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);

    // Single-cycle result; shift ops land here only when shamt is zero.
    always_comb begin
        imm_result = '0;
        imm_taken  = 1'b0;
        if (bus.is_branch) begin
            case (bus.Operation)
                4'b1000: imm_taken = (bus.SrcA == bus.SrcB);
                4'b1101: imm_taken = (bus.SrcA != bus.SrcB);
                4'b1110: imm_taken = lt_signed;
                4'b1111: imm_taken = !lt_signed;
                default: imm_taken = 1'b0;
            endcase
            imm_result = {{(DATA_WIDTH-1){1'b0}}, imm_taken};
        end else begin
            case (bus.Operation)
                4'b0000: imm_result = bus.SrcA & bus.SrcB;
                4'b0001: imm_result = bus.SrcA | bus.SrcB;
                4'b0011: imm_result = bus.SrcA ^ bus.SrcB;
                4'b1011: imm_result = bus.SrcA + bus.SrcB;
                4'b1010: imm_result = bus.SrcA - bus.SrcB;
                4'b0010: imm_result = bus.SrcB;
                4'b1100: imm_result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
                4'b0100, 4'b0101, 4'b1101: imm_result = bus.SrcA;
                default: imm_result = '0;
            endcase
        end
    end

    always_comb begin
        shifted = work;
        case (sh_kind)
            SH_LL:   shifted = {work[DATA_WIDTH-2:0], 1'b0};
            SH_RL:   shifted = {1'b0, work[DATA_WIDTH-1:1]};
            SH_RA:   shifted = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (is_shift && shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work          <= '0;
            cnt           <= '0;
            sh_kind       <= SH_LL;
            bus.ALUResult <= '0;
            bus.BrTaken   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_shift && shamt != '0) begin
                            work <= bus.SrcA;
                            cnt  <= shamt;
                            case (bus.Operation)
                                4'b0100: sh_kind <= SH_LL;
                                4'b0101: sh_kind <= SH_RL;
                                default: sh_kind <= SH_RA;
                            endcase
                        end else begin
                            bus.ALUResult <= imm_result;
                            bus.BrTaken   <= imm_taken;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - SHAMT_WIDTH'(1);
                    // Final step publishes the shifted value on the edge that enters DONE.
                    if (last_step) begin
                        bus.ALUResult <= shifted;
                        bus.BrTaken   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
